// File: rtl/down_counter_bout.sv
// -----------------------------------------------------------------------------
// down_counter_bout
//   Loadable WIDTH-bit down-counter with a combinational borrow-out. Stages
//   cascade by feeding one stage's BOUT into the next stage's BIN while all
//   stages share EN, so that together they form a wider down-counter.
//
//   MODE selects what happens when a decrement is taken at zero:
//     0 : wrap to all ones
//     1 : reload from the value captured by the last LOAD (or INIT)
//     2 : one-shot; hold at zero, raise DONE and ignore EN/BIN until LOAD
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   INIT     reset value of the count and of the reload register (truncated)
//   MODE     terminal-count behaviour, see above
//
// Ports
//   CLK       in   clock, all state on the rising edge
//   RESET     in   synchronous reset, active-high
//   LOAD      in   load LOAD_VAL into the count and the reload register
//   LOAD_VAL  in   value captured when LOAD=1
//   EN        in   count enable
//   BIN       in   borrow-in (tie 1 when standalone)
//   O         out  current count (registered)
//   BOUT      out  borrow-out, 1 when a decrement is taken while O==0
//   DONE      out  registered, 1 while a one-shot counter is stopped
// -----------------------------------------------------------------------------
module down_counter_bout #(
  parameter int          WIDTH = 4,
  parameter int unsigned INIT  = 0,
  parameter int          MODE  = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             EN,
  input  logic             BIN,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  state_t           state_p0;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_p0;
  logic [WIDTH-1:0] reload_nxt;
  logic             done_p0;
  logic             done_nxt;
  logic             dec;
  logic             at_zero;

  // Value taken by a decrement at zero. In one-shot mode the count simply
  // stays at zero; the stop itself is handled by the state machine.
  function automatic logic [WIDTH-1:0] zero_next(input logic [WIDTH-1:0] rl);
    logic [WIDTH-1:0] v;
    case (MODE)
      0:       v = '1;
      1:       v = rl;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Decrement qualification and borrow-out. RESET and LOAD both suppress the
  // decrement, which also keeps BOUT low in those cycles.
  always_comb begin
    dec        = EN & BIN & ~LOAD & ~RESET & (state_p0 == ST_RUN);
    at_zero    = (count_p0 == '0);
    BOUT       = dec & at_zero;

    state_nxt  = state_p0;
    count_nxt  = count_p0;
    reload_nxt = reload_p0;
    done_nxt   = done_p0;

    if (LOAD) begin
      count_nxt  = LOAD_VAL;
      reload_nxt = LOAD_VAL;
      done_nxt   = 1'b0;
      state_nxt  = ST_RUN;
    end else if (dec) begin
      if (!at_zero) begin
        count_nxt = count_p0 - WIDTH'(1);
      end else begin
        count_nxt = zero_next(reload_p0);
        if (MODE == 2) begin
          done_nxt  = 1'b1;
          state_nxt = ST_STOP;
        end
      end
    end
  end

  // ---- stage p0: architectural state ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_p0  <= ST_RUN;
      count_p0  <= INIT_V;
      reload_p0 <= INIT_V;
      done_p0   <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      count_p0  <= count_nxt;
      reload_p0 <= reload_nxt;
      done_p0   <= done_nxt;
    end
  end

  assign O    = count_p0;
  assign DONE = done_p0;

endmodule

// File: tb/tb_down_counter_bout.sv
module tb_down_counter_bout;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LOAD = 1'b0;
  logic [3:0] LOAD_VAL = 4'd0;
  logic       EN = 1'b0;
  logic       BIN = 1'b0;

  logic [3:0] o0, o1, o2, clo, chi;
  logic       b0, b1, b2, cblo, cbhi;
  logic       d0, d1, d2, cdlo, cdhi;

  always #5 CLK = ~CLK;

  down_counter_bout #(.WIDTH(4), .INIT(0), .MODE(0)) u_m0 (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .EN(EN), .BIN(BIN),
    .O(o0), .BOUT(b0), .DONE(d0));
  down_counter_bout #(.WIDTH(4), .INIT(0), .MODE(1)) u_m1 (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .EN(EN), .BIN(BIN),
    .O(o1), .BOUT(b1), .DONE(d1));
  down_counter_bout #(.WIDTH(4), .INIT(0), .MODE(2)) u_m2 (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .EN(EN), .BIN(BIN),
    .O(o2), .BOUT(b2), .DONE(d2));

  // Two cascaded wrap stages: shared EN and RESET, never loaded.
  down_counter_bout #(.WIDTH(4), .INIT(0), .MODE(0)) u_lo (
    .CLK(CLK), .RESET(RESET), .LOAD(1'b0), .LOAD_VAL(4'd0), .EN(EN), .BIN(1'b1),
    .O(clo), .BOUT(cblo), .DONE(cdlo));
  down_counter_bout #(.WIDTH(4), .INIT(0), .MODE(0)) u_hi (
    .CLK(CLK), .RESET(RESET), .LOAD(1'b0), .LOAD_VAL(4'd0), .EN(EN), .BIN(cblo),
    .O(chi), .BOUT(cbhi), .DONE(cdhi));

  typedef struct packed {
    logic [2:0][3:0] o;
    logic [2:0]      b;
    logic [2:0]      d;
    logic [7:0]      c;
    logic [1:0]      cb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: plain integers, one counter per mode plus an 8-bit count.
  int m_o[3];
  int m_rl[3];
  bit m_stop[3];
  int m_c;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the counter presents a result every cycle; compare mid-cycle.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("m0_O", o0, e.o[0]);  chk("m0_BOUT", b0, e.b[0]);  chk("m0_DONE", d0, e.d[0]);
      chk("m1_O", o1, e.o[1]);  chk("m1_BOUT", b1, e.b[1]);  chk("m1_DONE", d1, e.d[1]);
      chk("m2_O", o2, e.o[2]);  chk("m2_BOUT", b2, e.b[2]);  chk("m2_DONE", d2, e.d[2]);
      chk("cas_O", {chi, clo}, e.c);
      chk("cas_BOUT_lo", cblo, e.cb[0]);
      chk("cas_BOUT_hi", cbhi, e.cb[1]);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_o[i] = 0; m_rl[i] = 0; m_stop[i] = 0;
    end
    m_c = 0;
  endtask

  // Drive one cycle of stimulus, queue the expected observation for this
  // cycle, then advance the model across the clock edge.
  task automatic cyc(input bit rst, input bit ld, input int lv, input bit en, input bit bin);
    exp_t e;
    bit   dec;
    RESET = rst; LOAD = ld; LOAD_VAL = 4'(lv); EN = en; BIN = bin;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      dec = en && bin && !ld && !rst && !m_stop[i];
      e.o[i] = 4'(m_o[i]);
      e.b[i] = dec && (m_o[i] == 0);
      e.d[i] = m_stop[i];
    end
    e.c     = 8'(m_c);
    e.cb[0] = en && !rst && ((m_c % 16) == 0);
    e.cb[1] = en && !rst && (m_c == 0);
    q.push_back(e);

    for (int i = 0; i < 3; i++) begin
      dec = en && bin && !ld && !rst && !m_stop[i];
      if (rst) begin
        m_o[i] = 0; m_rl[i] = 0; m_stop[i] = 0;
      end else if (ld) begin
        m_o[i] = lv; m_rl[i] = lv; m_stop[i] = 0;
      end else if (dec) begin
        if (m_o[i] > 0)   m_o[i] = m_o[i] - 1;
        else if (i == 0)  m_o[i] = 15;
        else if (i == 1)  m_o[i] = m_rl[i];
        else              m_stop[i] = 1;
      end
    end
    if (rst)     m_c = 0;
    else if (en) m_c = (m_c + 255) % 256;

    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Initial reset edge; outputs are unknown before it, so nothing is queued.
    @(posedge CLK);
    #1;
    model_reset();

    // Reset held with EN=1: BOUT must stay low.
    cyc(1, 0, 0, 1, 1);
    // Free run from zero: first cycle borrows, then F,E,...; cascade wraps.
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 1);
    // Load 5 and run past several reloads / the one-shot stop.
    cyc(0, 1, 5, 1, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 1);
    // Load 3, stop, then keep enabling while stopped.
    cyc(0, 1, 3, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1);
    // Load while at zero with EN=1: no borrow, count becomes 9.
    cyc(0, 1, 9, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
    // Reset together with LOAD.
    cyc(1, 1, 12, 1, 1);
    cyc(0, 0, 0, 0, 1);
    // Load 7, then toggle BIN.
    cyc(0, 1, 7, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, (i % 2) == 0);
    // Reload register at zero: mode 1 stays at 0 and borrows every cycle.
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0);

    RESET = 1'b0; LOAD = 1'b0; EN = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
